// File: rtl/syscall_read_unit.sv
// syscall_read_unit
// Input-side syscall service for the single-cycle MIPS core. It handles
// read_int, which parses a decimal integer from the console byte stream and
// returns it for $v0, and read_string, which copies a line from the console
// into memory at $a0 as a NUL-terminated string of at most $a1 bytes.
// The core stalls while busy is high. Every output is registered.

module syscall_read_unit #(
    parameter logic [31:0] SVC_READ_INT = 32'd5,
    parameter logic [31:0] SVC_READ_STR = 32'd8,
    parameter logic [7:0]  NEWLINE      = 8'h0A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] service,
    input  logic [31:0] arg_addr,
    input  logic [31:0] arg_len,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        busy,
    output logic        result_we,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INT_RX = 3'd1,
        ST_STR_RX = 3'd2,
        ST_TERM   = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;

    // Big-endian lane select: byte offset 0 lives in bits 31:24, so it is be[3].
    function automatic logic [3:0] lane_be(input logic [1:0] offset);
        logic [3:0] be;
        case (offset)
            2'd0:    be = 4'b1000;
            2'd1:    be = 4'b0100;
            2'd2:    be = 4'b0010;
            2'd3:    be = 4'b0001;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // True for the ASCII characters '0' through '9'.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

    state_t      state_r;
    logic [31:0] acc_r;
    logic        neg_r;
    logic        first_r;
    logic [31:0] ptr_r;
    logic [31:0] rem_r;

    logic        rx_ready_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_be_r;
    logic        busy_r;
    logic        result_we_r;
    logic [31:0] result_r;
    logic        done_r;

    logic        accept_s;
    logic [31:0] acc_mac_s;
    logic [31:0] int_final_s;
    logic [31:0] rem_dec_s;
    logic [31:0] ptr_inc_s;
    logic [31:0] word_addr_s;

    // Datapath helpers: handshake, decimal multiply-accumulate, sign fix-up, pointer math.
    always_comb begin
        accept_s    = rx_valid & rx_ready_r;
        // acc*10 + digit, wrapping modulo 2^32. The digit value is the low
        // nibble of its ASCII code.
        acc_mac_s   = (acc_r << 3) + (acc_r << 1) + {28'd0, rx_data[3:0]};
        int_final_s = neg_r ? (32'd0 - acc_r) : acc_r;
        rem_dec_s   = rem_r - 32'd1;
        ptr_inc_s   = ptr_r + 32'd1;
        word_addr_s = {ptr_r[31:2], 2'b00};
    end

    // Control FSM and all registered outputs. Strobes default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            acc_r       <= 32'd0;
            neg_r       <= 1'b0;
            first_r     <= 1'b0;
            ptr_r       <= 32'd0;
            rem_r       <= 32'd0;
            rx_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_be_r    <= 4'b0000;
            busy_r      <= 1'b0;
            result_we_r <= 1'b0;
            result_r    <= 32'd0;
            done_r      <= 1'b0;
        end else begin
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            result_we_r <= 1'b0;
            done_r      <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start && (service == SVC_READ_INT)) begin
                        acc_r      <= 32'd0;
                        neg_r      <= 1'b0;
                        first_r    <= 1'b1;
                        state_r    <= ST_INT_RX;
                        busy_r     <= 1'b1;
                        rx_ready_r <= 1'b1;
                    end else if (start && (service == SVC_READ_STR)) begin
                        ptr_r  <= arg_addr;
                        rem_r  <= arg_len;
                        busy_r <= 1'b1;
                        if (arg_len == 32'd0) begin
                            state_r <= ST_FIN;
                        end else if (arg_len == 32'd1) begin
                            // Room only for the terminator.
                            state_r <= ST_TERM;
                        end else begin
                            state_r    <= ST_STR_RX;
                            rx_ready_r <= 1'b1;
                        end
                    end else begin
                        // Unknown service codes are ignored.
                        state_r <= ST_IDLE;
                    end
                end

                ST_INT_RX: begin
                    if (accept_s) begin
                        first_r <= 1'b0;
                        if (first_r && (rx_data == ASCII_MINUS)) begin
                            neg_r <= 1'b1;
                        end else if (is_digit(rx_data)) begin
                            acc_r <= acc_mac_s;
                        end else begin
                            // Any non-digit ends the number and is consumed.
                            result_r    <= int_final_s;
                            result_we_r <= 1'b1;
                            done_r      <= 1'b1;
                            busy_r      <= 1'b0;
                            rx_ready_r  <= 1'b0;
                            state_r     <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_INT_RX;
                    end
                end

                ST_STR_RX: begin
                    if (accept_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= word_addr_s;
                        mem_be_r    <= lane_be(ptr_r[1:0]);
                        mem_wdata_r <= {4{rx_data}};
                        ptr_r       <= ptr_inc_s;
                        rem_r       <= rem_dec_s;
                        // Stop on newline (which is kept) or when only the NUL slot remains.
                        if ((rx_data == NEWLINE) || (rem_dec_s == 32'd1)) begin
                            state_r    <= ST_TERM;
                            rx_ready_r <= 1'b0;
                        end else begin
                            state_r <= ST_STR_RX;
                        end
                    end else begin
                        state_r <= ST_STR_RX;
                    end
                end

                ST_TERM: begin
                    // The NUL write, done and the return to idle land together.
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= word_addr_s;
                    mem_be_r    <= lane_be(ptr_r[1:0]);
                    mem_wdata_r <= 32'd0;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    rx_ready_r  <= 1'b0;
                    state_r     <= ST_IDLE;
                end

                ST_FIN: begin
                    // Zero-length buffer: nothing to write.
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    rx_ready_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end

                default: begin
                    busy_r     <= 1'b0;
                    rx_ready_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready  = rx_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign busy      = busy_r;
    assign result_we = result_we_r;
    assign result    = result_r;
    assign done      = done_r;

endmodule

// File: tb/tb_syscall_read_unit.sv
// Directed testbench for syscall_read_unit. A negedge monitor logs every
// memory write and strobe, and the expected values are hand-computed constants.

module tb_syscall_read_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] service;
    logic [31:0] arg_addr;
    logic [31:0] arg_len;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        busy;
    logic        result_we;
    logic [31:0] result;
    logic        done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_be_q[$];
    logic        wr_done_q[$];
    int          done_cnt = 0;
    int          rwe_cnt  = 0;

    syscall_read_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .service   (service),
        .arg_addr  (arg_addr),
        .arg_len   (arg_len),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .busy      (busy),
        .result_we (result_we),
        .result    (result),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log DUT writes and strobes away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_be_q.push_back(mem_be);
            wr_done_q.push_back(done);
        end
        if (done)      done_cnt++;
        if (result_we) rwe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_be_q.delete();
        wr_done_q.delete();
        done_cnt = 0;
        rwe_cnt  = 0;
    endtask

    // Pulse start for one cycle; returns at the negedge after the capture edge.
    task automatic start_op(input logic [31:0] svc, input logic [31:0] a0, input logic [31:0] a1);
        start    = 1'b1;
        service  = svc;
        arg_addr = a0;
        arg_len  = a1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte; returns at the negedge after it was taken, or gives up.
    task automatic send_byte(input logic [7:0] b, output logic taken);
        int n;
        n        = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready) begin
            @(negedge clk);
            taken = 1'b1;
        end else begin
            taken = 1'b0;
        end
    endtask

    task automatic send_str(input string s, input string tag);
        logic tk;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], tk);
            check_eq({tag, "_accept"}, {31'd0, tk}, 32'd1);
        end
    endtask

    task automatic run_int(input string s, input logic [31:0] exp, input string tag);
        clear_log();
        start_op(32'd5, 32'd0, 32'd0);
        send_str(s, tag);
        // Now one cycle after the terminator was accepted.
        check_eq({tag, "_result"}, result, exp);
        check_eq({tag, "_rwe"}, {31'd0, result_we}, 32'd1);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_wr(input int idx, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d, input string tag);
        if (idx < wr_addr_q.size()) begin
            check_eq({tag, "_addr"}, wr_addr_q[idx], a);
            check_eq({tag, "_be"}, {28'd0, wr_be_q[idx]}, {28'd0, be});
            check_eq({tag, "_data"}, wr_data_q[idx], d);
        end else begin
            check_eq({tag, "_present"}, wr_addr_q.size(), idx + 1);
        end
    endtask

    initial begin
        logic tk;
        reset    = 1'b0;
        start    = 1'b0;
        service  = 32'd0;
        arg_addr = 32'd0;
        arg_len  = 32'd0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;

        // Reset state
        #2;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check_eq("rst_done", {30'd0, done, result_we}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // read_int
        run_int("123\n", 32'h0000007B, "int123");
        run_int("-42\n", 32'hFFFFFFD6, "intneg42");
        run_int("\n", 32'h00000000, "intempty");
        run_int("-\n", 32'h00000000, "intlone");
        run_int("4294967297\n", 32'h00000001, "intwrap");
        run_int("5-", 32'h00000005, "intminus2");

        // read_string, unaligned start crossing a word boundary
        clear_log();
        start_op(32'd8, 32'h10000002, 32'd8);
        check_eq("hi_busy", {31'd0, busy}, 32'd1);
        send_str("hi\n", "hi");
        rx_valid = 1'b0;
        wait_done();
        check_eq("hi_nwr", wr_addr_q.size(), 32'd4);
        check_wr(0, 32'h10000000, 4'b0010, 32'h68686868, "hi_w0");
        check_wr(1, 32'h10000000, 4'b0001, 32'h69696969, "hi_w1");
        check_wr(2, 32'h10000004, 4'b1000, 32'h0A0A0A0A, "hi_w2");
        check_wr(3, 32'h10000004, 4'b0100, 32'h00000000, "hi_w3");
        if (wr_done_q.size() == 4) check_eq("hi_nul_done", {31'd0, wr_done_q[3]}, 32'd1);
        else check_eq("hi_nul_done_n", wr_done_q.size(), 32'd4);
        check_eq("hi_done_cnt", done_cnt, 32'd1);
        check_eq("hi_no_rwe", rwe_cnt, 32'd0);
        check_eq("hi_result_hold", result, 32'h00000005);

        // read_string, buffer fills before newline
        clear_log();
        start_op(32'd8, 32'h20000000, 32'd4);
        send_str("abc", "abc");
        check_eq("abc_rx_ready", {31'd0, rx_ready}, 32'd0);
        send_byte(8'h64, tk);
        check_eq("abc_d_taken", {31'd0, tk}, 32'd0);
        rx_valid = 1'b0;
        wait_done();
        check_eq("abc_nwr", wr_addr_q.size(), 32'd4);
        check_wr(0, 32'h20000000, 4'b1000, 32'h61616161, "abc_w0");
        check_wr(2, 32'h20000000, 4'b0010, 32'h63636363, "abc_w2");
        check_wr(3, 32'h20000000, 4'b0001, 32'h00000000, "abc_w3");
        check_eq("abc_done_cnt", done_cnt, 32'd1);

        // read_string with zero-length buffer
        clear_log();
        start_op(32'd8, 32'h40000000, 32'd0);
        check_eq("len0_busy", {31'd0, busy}, 32'd1);
        check_eq("len0_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check_eq("len0_done", {31'd0, done}, 32'd1);
        check_eq("len0_busy_off", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check_eq("len0_nwr", wr_addr_q.size(), 32'd0);

        // read_string with room only for the NUL
        clear_log();
        start_op(32'd8, 32'h50000003, 32'd1);
        @(negedge clk);
        check_eq("len1_done", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
        check_eq("len1_nwr", wr_addr_q.size(), 32'd1);
        check_wr(0, 32'h50000000, 4'b0001, 32'h00000000, "len1_w0");

        // Reset in the middle of a string
        clear_log();
        start_op(32'd8, 32'h30000000, 32'd16);
        send_str("xy", "rst");
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("rst_mid_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_nwr", wr_addr_q.size(), 32'd2);
        check_eq("rst_mid_no_done", done_cnt, 32'd0);
        start_op(32'd11, 32'h0, 32'h0);
        check_eq("svc11_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("svc11_busy2", {31'd0, busy}, 32'd0);
        check_eq("svc11_no_done", done_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/syscall_read_unit.md
Name: syscall_read_unit

Overview:
- Input-direction syscall service for the single-cycle MIPS core; the counterpart of the existing print-integer and print-string handlers.
- Services read_int (v0=5) and read_string (v0=8). It consumes ASCII bytes from a console byte stream and either returns a 32-bit integer for $v0 or writes a NUL-terminated string into data/heap memory at $a0.
- The core stalls while busy is high.
- Memory is big-endian: byte offset k of a word occupies bits [31-8k -: 8].

Parameters:
- SVC_READ_INT, 5, service code for integer read
- SVC_READ_STR, 8, service code for string read
- NEWLINE, 8'h0A, line terminator byte

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  syscall strobe from the core (SysCall decode)
- service  in  32  $v0 value at start
- arg_addr  in  32  $a0: string buffer byte address
- arg_len  in  32  $a1: buffer size in bytes, including NUL
- rx_valid  in  1  console byte available
- rx_data  in  8  console byte
- rx_ready  out  1  unit accepts rx_data this cycle
- mem_we  out  1  byte write strobe
- mem_addr  out  32  word-aligned byte address (ptr & ~3)
- mem_wdata  out  32  byte replicated into all four lanes
- mem_be  out  4  one-hot lane enable; be[3] = offset 0 (bits 31:24)
- busy  out  1  operation in progress; core stalls
- result_we  out  1  one-cycle strobe to write result into $v0
- result  out  32  integer read result
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset asserted: state=IDLE; rx_ready, mem_we, mem_be, result_we, done, busy = 0; result, mem_addr, mem_wdata = 0.
- Reset mid-operation aborts immediately. No further writes occur and no done pulse is issued.
- All outputs are registered. busy = (state != IDLE).
- rx_ready = 1 only in states INT_RX and STR_RX. A byte transfers on a rising edge where rx_valid & rx_ready.
- Starting an operation:
  - IDLE with start and service=SVC_READ_INT: clear acc and neg, go to INT_RX.
  - IDLE with start and service=SVC_READ_STR: ptr=arg_addr, rem=arg_len.
    - rem=0: go to FIN.
    - rem=1: go to TERM.
    - otherwise: go to STR_RX.
  - Any other service code: ignored; stays IDLE with busy=0.
  - start while busy: ignored.
- INT_RX, per accepted byte:
  - '-' as the first byte accepted: neg=1.
  - '0'..'9': acc = acc*10 + digit, modulo 2^32. Overflow wraps silently.
  - Any other byte (NEWLINE included) terminates and is consumed. On that edge: result = neg ? -acc : acc, result_we=1, done=1, state=IDLE.
  - Empty input or a lone '-' gives result 0.
- STR_RX, per accepted byte b:
  - Next cycle: mem_we=1, mem_addr=ptr&~3, lane (ptr[1:0]) enabled, wdata = b in all lanes.
  - Then ptr += 1 and rem -= 1.
  - If b==NEWLINE or the new rem==1: state=TERM on the same edge. The newline itself is stored.
  - Throughput is 1 byte/cycle.
- TERM (one cycle):
  - Next edge loads the NUL write at ptr (same lane rules), done=1, state=IDLE.
  - The NUL write, done, and busy=0 share one cycle.
- FIN (rem=0 case): next edge sets done=1, state=IDLE. No memory write.
- Unaligned arg_addr is supported. Each byte independently selects its lane; crossing a word boundary needs no special handling.
- ptr wraps modulo 2^32. No bounds check against the heap base.
- Idle cycles with rx_valid=0 inside INT_RX/STR_RX: hold state indefinitely. There is no timeout.
- result holds its value until the next read_int completes.
- result_we is never asserted for read_string.

Test Plan:
- read_int, stream "123\n" → result_we+done one cycle after '\n' accepted, result=32'h0000007B, busy low that cycle.
- read_int, stream "-42\n" → result=32'hFFFFFFD6. Stream "\n" → result=0.
- read_string, a0=32'h10000002, a1=8, stream "hi\n" → byte writes:
  - 0x10000000 be=0010 'h'
  - 0x10000000 be=0001 'i'
  - 0x10000004 be=1000 0x0A
  - 0x10000004 be=0100 0x00
  - then done; 4 writes total.
- read_string, a1=4, stream "abcdef" → writes 'a','b','c', then NUL at a0+3. rx_ready low after 'c'; 'd' is not consumed.
- read_string with a1=0 → no writes, done two cycles after start. With a1=1 → a single NUL write at a0, then done.
- Reset (reset=0) asserted mid-string after 2 bytes → mem_we=0 immediately, busy=0, no done. A subsequent start=1 with service=11 → ignored, busy stays 0.
